demo_06: RTL and testbench
==========================

DEMO_06 -- requirements
Module: demo_06

Interface
REQ-001 Parameters: none; operand width is fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 A  input  4  operand A, unsigned.
REQ-005 B  input  4  operand B, unsigned.
REQ-006 C0  input  1  carry-in.
REQ-007 in_valid  input  1  qualifies A/B/C0 for capture this cycle.
REQ-008 F  output  4  registered sum bits.
REQ-009 C4  output  1  registered carry-out.
REQ-010 out_valid  output  1  high for one cycle per accepted input.
REQ-011 PG  output  1  registered group propagate (present only with DEMO_06_GROUP_PG_EN).
REQ-012 GG  output  1  registered group generate (present only with DEMO_06_GROUP_PG_EN).

Function
REQ-013 Per-bit terms SHALL be Gi = Ai&Bi, Pi = Ai^Bi for i = 0..3.
REQ-014 Carries SHALL use two-level lookahead, not ripple: C1 = G0|P0C0; C2 = G1|P1G0|P1P0C0; C3 and C4 expanded likewise from G/P and C0.
REQ-015 Sum SHALL be Fi = Pi ^ Ci, with C0 the input carry.
REQ-016 {C4,F} SHALL equal A + B + C0 (5-bit unsigned result) for all 512 input combinations.
REQ-017 On a clk rising edge with in_valid=1, F, C4 (and PG/GG) SHALL load the result of the current A/B/C0; out_valid SHALL go 1 on that edge.
REQ-018 On a clk rising edge with in_valid=0, F, C4, PG, GG SHALL hold; out_valid SHALL go 0.
REQ-019 Latency SHALL be exactly 1 cycle from capture edge to valid result; throughput one result per cycle; back-to-back in_valid SHALL be accepted with no bubbles.
REQ-020 No backpressure: a result not consumed on its out_valid cycle remains on F/C4 until the next accepted input.
REQ-021 Boundary: 1111+1111+1 SHALL give F=1111, C4=1 (maximum); 0000+0000+0 SHALL give F=0000, C4=0.
REQ-022 Inputs SHALL be sampled only at the capture edge; changes between edges SHALL have no effect on outputs.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for clk, force F=0000, C4=0, out_valid=0, PG=0, GG=0.
REQ-024 While rst_n=0, in_valid SHALL be ignored; an input pending when reset asserts SHALL be discarded.
REQ-025 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first capture is possible on that edge.

Configuration
REQ-026 Macro DEMO_06_GROUP_PG_EN defined: PG = P3&P2&P1&P0 and GG = G3|P3G2|P3P2G1|P3P2P1G0 SHALL be registered alongside F/C4 for cascading into a second-level lookahead unit.
REQ-027 Macro undefined: PG and GG ports and their registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset: rst_n=0 mid-stream with out_valid=1 -> F=0000, C4=0, out_valid=0 immediately, before the next clk edge.
REQ-029 Carry chain: A=1111, B=1111, C0=1 -> F=1111, C4=1; A=1111, B=1100, C0=1 -> F=1100, C4=1.
REQ-030 Full propagate: A=0000, B=1111, C0=1 -> F=0000, C4=1 (PG=1, GG=0 when enabled); A=0001, B=0001, C0=1 -> F=0011, C4=0.
REQ-031 No carry-in: A=1111, B=1111, C0=0 -> F=1110, C4=1; A=0001, B=1100, C0=0 -> F=1101, C4=0.
REQ-032 Handshake: back-to-back in_valid over 3 cycles -> 3 consecutive out_valid pulses with matching results, each one cycle late; in_valid=0 -> outputs hold and out_valid=0.
REQ-033 Exhaustive: all 512 A/B/C0 combinations -> {C4,F} == A+B+C0, run with and without DEMO_06_GROUP_PG_EN.

Source files
------------

// File: rtl/demo_06.sv
// 4-bit two-level carry-lookahead adder with a registered, valid-qualified result.
// Define DEMO_06_GROUP_PG_EN to add registered group propagate/generate outputs.
module demo_06 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       C0,
   input  logic       in_valid,
   output logic [3:0] F,
   output logic       C4,
   output logic       out_valid
`ifdef DEMO_06_GROUP_PG_EN
  ,output logic       PG,
   output logic       GG
`endif
);

   logic [3:0] g;
   logic [3:0] p;
   logic       c1;
   logic       c2;
   logic       c3;
   logic       grp_p;
   logic       grp_g;
   logic       c4_n;
   logic [3:0] sum_n;

   always_comb begin
      g = A & B;
      p = A ^ B;
   end

   // Every carry is a flat sum of products of G/P and C0: no carry feeds another.
   always_comb begin
      c1 = g[0]
         | (p[0] & C0);
      c2 = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & C0);
      c3 = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & C0);
      grp_p = p[3] & p[2] & p[1] & p[0];
      grp_g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
      c4_n  = grp_g | (grp_p & C0);
      sum_n = p ^ {c3, c2, c1, C0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         F         <= 4'b0000;
         C4        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            F  <= sum_n;
            C4 <= c4_n;
         end
      end
   end

`ifdef DEMO_06_GROUP_PG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         PG <= 1'b0;
         GG <= 1'b0;
      end else if (in_valid) begin
         PG <= grp_p;
         GG <= grp_g;
      end
   end
`else
   logic unused_grp;
   assign unused_grp = grp_p;
`endif

endmodule

// File: tb/tb_demo_06.sv
// Self-checking bench for demo_06: vector table, handshake/reset sequences,
// randomized traffic and an exhaustive sweep against an arithmetic model.
module tb_demo_06;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] A = 4'd0;
   logic [3:0] B = 4'd0;
   logic       C0 = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] F;
   logic       C4;
   logic       out_valid;
`ifdef DEMO_06_GROUP_PG_EN
   logic       PG;
   logic       GG;
`endif

   int checks = 0;
   int errors = 0;

   int last_sum = 0;
   int last_pg  = 0;
   int last_gg  = 0;

   always #5 clk = ~clk;

   demo_06 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .C0        (C0),
      .in_valid  (in_valid),
      .F         (F),
      .C4        (C4),
      .out_valid (out_valid)
`ifdef DEMO_06_GROUP_PG_EN
     ,.PG        (PG),
      .GG        (GG)
`endif
   );

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       c0;
      logic [3:0] f;
      logic       c4;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string nm, input logic exp_v);
      chk({nm, "_valid"}, {31'd0, out_valid}, {31'd0, exp_v});
      chk({nm, "_sum"}, {27'd0, C4, F}, last_sum);
`ifdef DEMO_06_GROUP_PG_EN
      chk({nm, "_pg"}, {31'd0, PG}, last_pg);
      chk({nm, "_gg"}, {31'd0, GG}, last_gg);
`endif
   endtask

   // Model: result is plain addition; group P means every bit pair differs,
   // group G means the pair overflows on its own (carry-in 0).
   task automatic drive(input string nm, input int a, input int b,
                        input int c0, input logic v);
      @(negedge clk);
      A        = a[3:0];
      B        = b[3:0];
      C0       = c0[0];
      in_valid = v;
      @(posedge clk);
      #1;
      if (v) begin
         last_sum = a + b + c0;
         last_pg  = ((a ^ b) == 15) ? 1 : 0;
         last_gg  = ((a + b) > 15) ? 1 : 0;
      end
      check_out(nm, v);
   endtask

   initial begin
      vt[0] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
      vt[1] = '{4'hF, 4'hC, 1'b1, 4'hC, 1'b1};
      vt[2] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
      vt[3] = '{4'h1, 4'h1, 1'b1, 4'h3, 1'b0};
      vt[4] = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1};
      vt[5] = '{4'h1, 4'hC, 1'b0, 4'hD, 1'b0};
      vt[6] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};

      // Reset state, with a pending input that must be ignored
      A        = 4'hF;
      B        = 4'hF;
      C0       = 1'b1;
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_out("reset", 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_out("reset_hold", 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      for (int i = 0; i < 7; i++) begin
         drive("vec", vt[i].a, vt[i].b, vt[i].c0, 1'b1);
         chk("vec_f", {28'd0, F}, {28'd0, vt[i].f});
         chk("vec_c4", {31'd0, C4}, {31'd0, vt[i].c4});
      end
`ifdef DEMO_06_GROUP_PG_EN
      drive("pg_vec", 0, 15, 1, 1'b1);
      chk("pg_full", {31'd0, PG}, 32'd1);
      chk("gg_full", {31'd0, GG}, 32'd0);
`endif

      // Back-to-back, then idle hold
      drive("b2b0", 3, 4, 0, 1'b1);
      drive("b2b1", 9, 9, 1, 1'b1);
      drive("b2b2", 12, 5, 0, 1'b1);
      drive("idle0", 1, 2, 1, 1'b0);
      drive("idle1", 15, 15, 1, 1'b0);

      // Input wiggle between edges must not reach the outputs
      drive("cap", 6, 7, 1, 1'b1);
      A  = 4'hF;
      B  = 4'h0;
      C0 = 1'b0;
      #3;
      check_out("between", 1'b1);

      for (int i = 0; i < 300; i++) begin
         drive("rand", $urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 1), ($urandom_range(0, 3) != 0));
      end

      for (int i = 0; i < 512; i++) begin
         drive("exh", (i >> 5) & 15, (i >> 1) & 15, i & 1, 1'b1);
      end

      // Asynchronous reset while a result is valid
      drive("pre_rst", 10, 11, 1, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      last_sum = 0;
      last_pg  = 0;
      last_gg  = 0;
      check_out("async_rst", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive("post_rst", 3, 4, 1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
